wb_boot_loader: RTL
===================

Name: wb_boot_loader

Overview:
- Boot-time Wishbone master that copies a fixed image out of the synchronous boot ROM into RAM.
- Reads ROM word-by-word (registered-output ROM, 1-cycle read latency) and issues one classic Wishbone single write per word.
- Holds the CPU in reset until the copy completes.
- Sits between the boot ROM and the system Wishbone interconnect in wb_memory.

Parameters:
- data_width, 32, ROM word width and Wishbone data width; multiple of 8.
- addr_width, 8, ROM address width.
- wb_addr_width, 32, Wishbone byte-address width.
- base_addr, 32'h0000_0000, RAM byte address receiving ROM word 0.
- word_count, 2**addr_width, number of words copied; 0 to 2**addr_width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin copy; sampled only in IDLE
- rom_addr  out  addr_width  ROM address, registered
- rom_q  in  data_width  ROM data, valid one cycle after rom_addr sampled
- wb_adr_o  out  wb_addr_width  Wishbone byte address
- wb_dat_o  out  data_width  Wishbone write data
- wb_sel_o  out  data_width/8  byte selects
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error
- busy  out  1  copy in progress
- done  out  1  sticky, copy completed
- error  out  1  sticky, bus error seen
- cpu_rst_n  out  1  CPU reset, low until done

Behaviour:
- Reset (async, rst_n=0): state IDLE, index=0, rom_addr=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, wb_we_o=0, wb_cyc_o=0, wb_stb_o=0, busy=0, done=0, error=0, cpu_rst_n=0. Bus strobes drop immediately, even mid-cycle.
- States:
  - IDLE -> FETCH when start=1, word_count>0, and done=0 and error=0.
  - IDLE -> DONE when start=1 and word_count=0; no bus cycle is issued.
  - FETCH (1 cycle): rom_addr=index. ROM samples at end of cycle. -> LOAD.
  - LOAD (1 cycle): rom_q valid. At end of cycle register wb_dat_o=rom_q, wb_adr_o=base_addr+index*(data_width/8) (truncated to wb_addr_width, wraps), wb_sel_o=all ones, wb_we_o=1, wb_cyc_o=1, wb_stb_o=1. -> WRITE.
  - WRITE: hold all bus outputs stable until wb_ack_i or wb_err_i sampled high.
    - ack and index==word_count-1: drop cyc/stb/we -> DONE.
    - ack otherwise: drop cyc/stb/we, index++ -> FETCH.
    - err (err wins over simultaneous ack): drop cyc/stb/we, error=1 -> ERROR.
  - DONE: done=1, cpu_rst_n=1. Terminal until reset.
  - ERROR: error=1, cpu_rst_n stays 0. Terminal until reset.
- busy=1 in FETCH, LOAD and WRITE.
- start outside IDLE is ignored. The copy is one-shot per reset.
- Throughput: cyc/stb low for 2 cycles between words. With zero-wait ack, 3 cycles per word. First stb rises 2 cycles after the start edge.
- No cycle ever has stb=1 with cyc=0. wb_dat_o and wb_adr_o only change in LOAD.

Optional Feature:
- BOOT_VERIFY_EN defined: after the last write ack, a second pass runs over all words (FETCH -> LOAD -> READ). READ issues a Wishbone read (we=0) and compares wb_dat_i against the latched ROM word on ack.
  - Adds input port wb_dat_i (data_width).
  - Mismatch -> error=1, ERROR state.
  - DONE is reached only after all words compare equal.
- Not defined: no read pass, no wb_dat_i port, DONE directly after the last write.

Test Plan:
- ROM {11111111,22222222,33333333,44444444}, word_count=4, base_addr=0x1000, ack 1 cycle after stb -> writes to 0x1000/0x1004/0x1008/0x100C with matching data, sel=4'hF; done=1 and cpu_rst_n=1 exactly 12 cycles after the start edge.
- Same image, ack delayed 3 cycles per access -> adr/dat/we stable for 4 cycles per write; exactly 4 ack'd cycles; done=1.
- wb_err_i with wb_ack_i together on word 2 -> cyc/stb drop next cycle; error=1, done=0, cpu_rst_n=0; no access to 0x100C; later start pulses ignored.
- rst_n low during the WRITE of word 1, then start again -> cyc/stb low asynchronously; restart writes from 0x1000; all 4 words written.
- word_count=0, start=1 -> no cyc ever; done=1 next cycle. Start held high through a normal copy -> exactly one copy.
- BOOT_VERIFY_EN with readback word 3 returned as 0xDEADBEEF -> 4 writes, 4 reads, error=1 on the 4th read ack, done=0.

Source files
------------

// File: rtl/wb_boot_loader.sv
// wb_boot_loader: copies the boot ROM image into RAM over Wishbone; optional readback pass when BOOT_VERIFY_EN is defined
module wb_boot_loader #(
  parameter int data_width = 32,
  parameter int addr_width = 8,
  parameter int wb_addr_width = 32,
  parameter logic [wb_addr_width-1:0] base_addr = '0,
  parameter int word_count = 2**addr_width
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [addr_width-1:0]     rom_addr,
  input  logic [data_width-1:0]     rom_q,
  output logic [wb_addr_width-1:0]  wb_adr_o,
  output logic [data_width-1:0]     wb_dat_o,
`ifdef BOOT_VERIFY_EN
  input  logic [data_width-1:0]     wb_dat_i,
`endif
  output logic [data_width/8-1:0]   wb_sel_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      cpu_rst_n
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, READ, DONE, ERROR} state_t;
  localparam logic [wb_addr_width-1:0] STEP = wb_addr_width'(data_width / 8);
  localparam logic [addr_width-1:0] LAST = addr_width'(word_count - 1);
  state_t state_q, state_d;
  logic [addr_width-1:0] index_q, index_d;
  logic [wb_addr_width-1:0] adr_q, adr_d;
  logic [data_width-1:0] dat_q, dat_d;
  logic [data_width/8-1:0] sel_q, sel_d;
  logic we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
`ifdef BOOT_VERIFY_EN
  logic verify_q, verify_d;
`endif
  // Next-state and bus-output computation; everything holds unless a state changes it
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    we_d = we_q;
    cyc_d = cyc_q;
    stb_d = stb_q;
`ifdef BOOT_VERIFY_EN
    verify_d = verify_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = (word_count == 0) ? DONE : FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        dat_d = rom_q;
        adr_d = base_addr + wb_addr_width'(index_q) * STEP;
        sel_d = '1;
        cyc_d = 1'b1;
        stb_d = 1'b1;
`ifdef BOOT_VERIFY_EN
        we_d = !verify_q;
        state_d = verify_q ? READ : WRITE;
`else
        we_d = 1'b1;
        state_d = WRITE;
`endif
      end
      WRITE: if (wb_err_i || wb_ack_i) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d = 1'b0;
        if (wb_err_i) state_d = ERROR;
        else if (index_q == LAST) begin
`ifdef BOOT_VERIFY_EN
          index_d = '0;
          verify_d = 1'b1;
          state_d = FETCH;
`else
          state_d = DONE;
`endif
        end else begin
          index_d = index_q + 1'b1;
          state_d = FETCH;
        end
      end
`ifdef BOOT_VERIFY_EN
      READ: if (wb_err_i || wb_ack_i) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (wb_err_i || wb_dat_i != dat_q) state_d = ERROR;
        else if (index_q == LAST) state_d = DONE;
        else begin
          index_d = index_q + 1'b1;
          state_d = FETCH;
        end
      end
`endif
      default: ;
    endcase
  end
  // State and bus registers; async reset drops the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
`ifdef BOOT_VERIFY_EN
      verify_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      we_q <= we_d;
      cyc_q <= cyc_d;
      stb_q <= stb_d;
`ifdef BOOT_VERIFY_EN
      verify_q <= verify_d;
`endif
    end
  end
  assign rom_addr = index_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign busy = state_q inside {FETCH, LOAD, WRITE, READ};
  assign done = state_q == DONE;
  assign error = state_q == ERROR;
  assign cpu_rst_n = state_q == DONE;
endmodule
